reg_write_arb: RTL and testbench
================================

REG_WRITE_ARB -- requirements
Module: reg_write_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 4, meaning width of the shared register.
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit, a synchronous active-high reset.
REQ-005 Port req SHALL be an input, NREQ bits; req[i] high means requester i asks to write.
REQ-006 Port wdata SHALL be an input, NREQ*WIDTH bits; slice i is wdata[i*WIDTH +: WIDTH], the write data of requester i.
REQ-007 Port gnt SHALL be an output, NREQ bits, one-hot; it is a one-cycle grant pulse to the requester whose data was written.
REQ-008 Port q SHALL be an output, WIDTH bits, the shared register contents.
REQ-009 Port q_valid SHALL be an output, 1 bit, high once any write has occurred since reset.
REQ-010 Port src SHALL be an output, clog2(NREQ) bits, the index of the last requester written.
REQ-011 Port wr_count SHALL be an output, 8 bits, the number of writes modulo 256.

Function
REQ-012 The FSM SHALL have two states, IDLE and HOLD.
REQ-013 In IDLE with req == 0, the FSM SHALL stay in IDLE, leave q/src unchanged and drive gnt = 0.
REQ-014 In IDLE with req != 0, the edge SHALL select winner w as the first asserted req[i], scanning i = ptr, ptr+1, ... modulo NREQ.
REQ-015 On that same edge, q SHALL take wdata slice w, src SHALL take w, gnt SHALL take onehot(w), q_valid SHALL go to 1, wr_count SHALL increment, ptr SHALL take (w+1) mod NREQ, and the state SHALL go to HOLD.
REQ-016 In HOLD, gnt SHALL be held for exactly this one cycle, req SHALL be ignored, and the next edge SHALL clear gnt and return to IDLE; the maximum write rate is therefore one write per 2 cycles.
REQ-017 A requester SHALL deassert req in the cycle after it sees gnt; if req is still high at the next IDLE edge, it is treated as a new request.
REQ-018 wdata SHALL be sampled only on the winning IDLE edge; it is don't-care at all other times.
REQ-019 If all NREQ requesters hold req continuously, grants SHALL rotate 0,1,...,NREQ-1,0 with no starvation.
REQ-020 A req pulse that is high only during HOLD SHALL be lost; this is intended behaviour.
REQ-021 wr_count SHALL wrap from 255 to 0 without a flag.
REQ-022 gnt SHALL never have more than one bit set.

Reset
REQ-023 With reset high at an edge: q=0, src=0, gnt=0, q_valid=0, wr_count=0, ptr=0, state=IDLE.
REQ-024 Reset SHALL take priority over any write in the same cycle, including reset asserted while in HOLD.
REQ-025 The first IDLE edge after reset deasserts SHALL be able to accept a request.

Structure
REQ-026 The constants NREQ_DEF and WIDTH_DEF and the state encoding (IDLE=0, HOLD=1) SHALL live in the shared package reg_arb_pkg.
REQ-027 The round-robin selection SHALL be a combinational sub-module rr_pick, with inputs req and ptr and outputs any and idx.
REQ-028 All outputs SHALL be registered.

Verification
REQ-029 Reset then idle: reset 1 cycle, req=0 for 5 cycles -> q=0, q_valid=0, gnt=0, wr_count=0.
REQ-030 Single requester: req=4'b0100 with wdata slice 2 = 4'h7, dropped after gnt -> q=4'h7, src=2, gnt=4'b0100 for exactly 1 cycle, wr_count=1.
REQ-031 All requesters held: req=4'b1111 with slices 4'hF/4'h8/4'hB/4'h3 -> gnt order 0,1,2,3,0, with a grant every 2nd cycle and q following F,8,B,3,F.
REQ-032 Fairness: req=4'b1001 held continuously -> grants alternate 0 and 3; requesters 1 and 2 are never granted.
REQ-033 Reset mid-operation: reset asserted during HOLD -> next cycle gnt=0, q=0, q_valid=0, ptr=0; a subsequent req=4'b1111 grants requester 0 first.
REQ-034 Counter wrap: 256 single-requester writes -> wr_count=0 and q_valid=1.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared constants and state encoding for the round-robin shared-register writer.
package reg_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int c;
        c   = 0;
        any = |req;
        idx = '0;
        // Walk from farthest to nearest so the candidate closest to ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            if (req[IW'(c)]) idx = IW'(c);
        end
    end

endmodule

// File: rtl/reg_write_arb.sv
// Shared register with round-robin write arbitration: one write, then one HOLD cycle.
module reg_write_arb
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [IW-1:0]         src,
    output logic [7:0]            wr_count
);

    // Handshake: req[i] is a request level; gnt[i] is a one-cycle pulse that
    // means wdata slice i was written on the edge that raised it. The requester
    // drops req the cycle after gnt; a req still high at the next IDLE edge is
    // a new request, and req seen only during HOLD is ignored.

    arb_state_e             state, state_d;
    logic [IW-1:0]          ptr, ptr_d;
    logic [WIDTH-1:0]       q_d;
    logic [IW-1:0]          src_d;
    logic [NREQ-1:0]        gnt_d;
    logic                   q_valid_d;
    logic [7:0]             wr_count_d;
    logic                   pick_any;
    logic [IW-1:0]          pick_idx;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        q_d        = q;
        src_d      = src;
        gnt_d      = '0;
        q_valid_d  = q_valid;
        wr_count_d = wr_count;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    q_d             = wdata[int'(pick_idx)*WIDTH +: WIDTH];
                    src_d           = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    q_valid_d       = 1'b1;
                    wr_count_d      = wr_count + 8'd1;
                    ptr_d           = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                    state_d         = HOLD;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            q        <= '0;
            src      <= '0;
            gnt      <= '0;
            q_valid  <= 1'b0;
            wr_count <= 8'd0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            q        <= q_d;
            src      <= src_d;
            gnt      <= gnt_d;
            q_valid  <= q_valid_d;
            wr_count <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_reg_write_arb.sv
// Bench for reg_write_arb: directed scenarios plus randomized traffic against a reference model.
module tb_reg_write_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IW    = 2;
    localparam int VW    = NREQ + WIDTH + IW + 1 + 8;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [IW-1:0]         src;
    logic [7:0]            wr_count;

    int total;
    int bad;

    // reference model state
    int              m_ptr;
    int              m_src;
    int              m_cnt;
    logic [WIDTH-1:0] m_q;
    logic [NREQ-1:0]  m_gnt;
    logic             m_valid;
    bit               m_busy;

    logic [1:0] exp_q[$];

    reg_write_arb #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .q        (q),
        .q_valid  (q_valid),
        .src      (src),
        .wr_count (wr_count)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- reference model: a write may happen only on an edge that follows a non-writing edge ----
    task automatic model_edge();
        int w;
        if (reset) begin
            m_ptr = 0; m_src = 0; m_cnt = 0; m_q = '0; m_gnt = '0; m_valid = 1'b0; m_busy = 0;
        end else if (m_busy) begin
            m_gnt  = '0;
            m_busy = 0;
        end else if (req != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            m_q     = wdata[w*WIDTH +: WIDTH];
            m_src   = w;
            m_gnt   = NREQ'(1) << w;
            m_valid = 1'b1;
            m_cnt   = (m_cnt + 1) % 256;
            m_ptr   = (w + 1) % NREQ;
            m_busy  = 1;
        end else begin
            m_gnt = '0;
        end
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {gnt, q, src, q_valid, wr_count};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_gnt, m_q, IW'(m_src), m_valid, 8'(m_cnt)};
    endfunction

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    // ---- tests ----
    task automatic test_reset();
        reset = 1'b1;
        req   = '0;
        wdata = 16'($urandom);
        tick();
        reset = 1'b0;
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 5; i++) begin
            wdata = 16'($urandom);
            tick();
            total++;
            if ({q, q_valid, gnt, wr_count} !== {4'h0, 1'b0, 4'b0000, 8'd0}) begin
                bad++;
                $display("FAIL reset_idle: cycle %0d got q=%h v=%b g=%b c=%0d want all zero",
                         i, q, q_valid, gnt, wr_count);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req   = 4'b0100;
        wdata = {4'($urandom), 4'h7, 4'($urandom), 4'($urandom)};
        tick();
        req = '0;
        total++;
        if ({gnt, q, src, wr_count} !== {4'b0100, 4'h7, 2'd2, 8'd1}) begin
            bad++;
            $display("FAIL single_write: got g=%b q=%h s=%0d c=%0d want g=0100 q=7 s=2 c=1",
                     gnt, q, src, wr_count);
        end
        for (int i = 0; i < 3; i++) begin
            wdata = 16'($urandom);
            tick();
            total++;
            if (gnt !== 4'b0000 || q !== 4'h7 || dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL single_after: cycle %0d got %h want %h (gnt 0, q 7)",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_all_held();
        logic [WIDTH-1:0] exp_data[4];
        logic [1:0]       w;
        int               grants;
        exp_data = '{4'hF, 4'h8, 4'hB, 4'h3};
        do_reset();
        exp_q.delete();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        grants = 0;
        req    = 4'b1111;
        wdata  = {4'h3, 4'hB, 4'h8, 4'hF};
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (e % 2 == 0) begin
                w = exp_q.pop_front();
                if (gnt !== (NREQ'(1) << w) || q !== exp_data[w] || src !== w) begin
                    bad++;
                    $display("FAIL all_held_grant: edge %0d got g=%b q=%h s=%0d want g=%b q=%h s=%0d",
                             e, gnt, q, src, NREQ'(1) << w, exp_data[w], w);
                end else begin
                    grants++;
                end
            end else if (gnt !== 4'b0000 || dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL all_held_gap: edge %0d got %h want %h", e, dut_vec(), exp_vec());
            end
        end
        req = '0;
        total++;
        if (grants != 5 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL all_held_count: got %0d good grants want 5", grants);
        end
    endtask

    task automatic test_fairness();
        int      n0, n3;
        logic [1:0] last;
        do_reset();
        n0 = 0; n3 = 0; last = 2'd3;
        req = 4'b1001;
        for (int e = 0; e < 12; e++) begin
            wdata = 16'($urandom);
            tick();
            total++;
            if ((gnt & 4'b0110) != 0 || dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL fairness: edge %0d got %h want %h", e, dut_vec(), exp_vec());
            end
            if (gnt == 4'b0001) begin
                if (last != 2'd3) begin
                    bad++; total++;
                    $display("FAIL fairness_alt: got grant 0 twice, want alternation");
                end
                last = 2'd0; n0++;
            end else if (gnt == 4'b1000) begin
                if (last != 2'd0) begin
                    bad++; total++;
                    $display("FAIL fairness_alt: got grant 3 twice, want alternation");
                end
                last = 2'd3; n3++;
            end
        end
        req = '0;
        total++;
        if (n0 != 3 || n3 != 3) begin
            bad++;
            $display("FAIL fairness_count: got n0=%0d n3=%0d want 3 and 3", n0, n3);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req   = 4'b0100;
        wdata = 16'($urandom);
        tick();
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        reset = 1'b0;
        total++;
        if ({gnt, q, q_valid, src, wr_count} !== {4'b0000, 4'h0, 1'b0, 2'd0, 8'd0}) begin
            bad++;
            $display("FAIL reset_mid_clear: got g=%b q=%h v=%b s=%0d c=%0d want zeros",
                     gnt, q, q_valid, src, wr_count);
        end
        wdata = 16'($urandom);
        tick();
        req = '0;
        total++;
        if (gnt !== 4'b0001 || dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_mid_first: got %h want %h (gnt 0001)", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_lost_pulse();
        do_reset();
        req   = 4'b0001;
        wdata = 16'($urandom);
        tick();
        req = 4'b0010;
        tick();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (gnt !== 4'b0000 || wr_count !== 8'd1 || dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL lost_pulse: cycle %0d got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        int grants;
        do_reset();
        grants = 0;
        req = 4'b0001;
        for (int e = 0; e < 512; e++) begin
            wdata = 16'($urandom);
            tick();
            if (gnt == 4'b0001) grants++;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_step: edge %0d got %h want %h", e, dut_vec(), exp_vec());
            end
        end
        req = '0;
        total++;
        if (wr_count !== 8'd0 || q_valid !== 1'b1 || grants != 256) begin
            bad++;
            $display("FAIL wrap_final: got c=%0d v=%b grants=%0d want c=0 v=1 grants=256",
                     wr_count, q_valid, grants);
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 600; e++) begin
            reset = ($urandom_range(0, 49) == 0);
            req   = 4'($urandom_range(0, 15));
            wdata = 16'($urandom);
            tick();
            total++;
            if (dut_vec() !== exp_vec() || !$onehot0(gnt)) begin
                bad++;
                $display("FAIL random: edge %0d req=%b got %h want %h", e, req, dut_vec(), exp_vec());
            end
        end
        reset = 1'b0;
        req   = '0;
    endtask

    // ---- sequence and report ----
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req   = '0;
        wdata = '0;
        m_ptr = 0; m_src = 0; m_cnt = 0; m_q = '0; m_gnt = '0; m_valid = 1'b0; m_busy = 0;
        #2;
        test_reset();
        test_single();
        test_all_held();
        test_fairness();
        test_reset_mid();
        test_lost_pulse();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
